egress_arbiter: RTL and testbench
=================================

EGRESS_ARBITER -- requirements
Module: egress_arbiter

Interface
REQ-001 SHALL have parameter OUT_PORT, default 0, meaning the 2-bit egress index this arbiter serves.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning the tdata width.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port en, input, 1, enabling new grants.
REQ-006 SHALL have ports in_tdata[i], input, DATA_WIDTH, for i=0..3, carrying filter egress data.
REQ-007 SHALL have ports in_tvalid[i], in_tlast[i], input, 1 each, for i=0..3.
REQ-008 SHALL have ports in_tdest[i], input, 2, for i=0..3, giving the requested output port.
REQ-009 SHALL have ports in_tready[i], output, 1, for i=0..3; the top level ORs these across arbiters.
REQ-010 SHALL have ports out_tdata (DATA_WIDTH), out_tvalid, out_tlast (1 each), out_tsrc (2, granted input index), all outputs.
REQ-011 SHALL have port out_tready, input, 1.
REQ-012 SHALL have port frames_out, output, 32, a count of frames emitted.

Function
REQ-013 SHALL treat input i as requesting when in_tvalid[i]=1 and in_tdest[i]=OUT_PORT.
REQ-014 SHALL implement two states: IDLE (no grant) and LOCKED (grant to input g).
REQ-015 IDLE: if en=1 and any input requests, SHALL select the first requester scanning g_last+1, g_last+2, ... mod 4, and enter LOCKED with g latched on the next edge.
REQ-016 IDLE: if en=0 or there are no requests, SHALL remain in IDLE with in_tready all 0.
REQ-017 LOCKED: SHALL drive in_tready[g] = !out_tvalid || out_tready; all other in_tready SHALL be 0.
REQ-018 LOCKED: a beat SHALL be accepted when in_tvalid[g] && in_tready[g]; acceptance SHALL NOT depend on in_tdest (tdest is sampled only at arbitration).
REQ-019 SHALL use a registered output slice with 1-cycle latency: an accepted beat appears on out_* on the next cycle, with out_tsrc=g.
REQ-020 out_tvalid SHALL stay high with data stable until out_tready=1; the slice SHALL sustain 1 beat/cycle while out_tready=1.
REQ-021 On acceptance of a beat with in_tlast=1: SHALL set g_last<=g, return to IDLE next cycle, and incur a one-cycle arbitration gap.
REQ-022 LOCKED with in_tvalid[g]=0: SHALL hold the grant indefinitely (bubble tolerated), with no timeout.
REQ-023 en deasserted while LOCKED: SHALL complete the current frame, then grant nothing.
REQ-024 frames_out SHALL increment by 1 when out_tvalid && out_tready && out_tlast, and SHALL wrap 0xFFFFFFFF->0.
REQ-025 SHALL be combinationally free of any out_tready->out_tvalid path; in_tready MAY depend combinationally on out_tready.

Reset
REQ-026 On reset assertion, SHALL immediately clear to: state IDLE, g_last=3 (first priority to input 0), out_tvalid=0, out_tlast=0, out_tdata=0, out_tsrc=0, frames_out=0, in_tready all 0.
REQ-027 A frame in flight at reset SHALL be discarded; no partial beats SHALL be emitted after reset release.
REQ-028 After deassertion, the first grant SHALL occur no earlier than the first clock edge.

Verification
REQ-029 OUT_PORT=1, en=1; input 2 sends a 3-beat frame, tdest=1, out_tready=1 -> out beats on cycles 2,3,4 after request, out_tsrc=2, tlast on the 3rd beat, frames_out=1.
REQ-030 Inputs 0,1,3 each hold a 2-beat frame (tdest=OUT_PORT) from reset -> grant order 0,1,3,0 with a 1-cycle gap between frames; no beats interleaved.
REQ-031 Input 0 requests with tdest≠OUT_PORT -> in_tready[0]=0 throughout, out_tvalid=0, frames_out=0.
REQ-032 Mid-frame, out_tready=0 for 3 cycles -> out_tdata/out_tlast held stable, in_tready[g]=0 while the slice is full, no beat lost or duplicated.
REQ-033 en deasserted during beat 2 of a 4-beat frame -> all 4 beats emitted, then the arbiter stays IDLE despite pending requests.
REQ-034 reset pulsed mid-frame, then the same input resends -> out_tvalid falls asynchronously, frames_out=0, and the new frame is emitted intact.

Source files
------------

// File: rtl/egress_arbiter.sv
// egress_arbiter: round-robin, frame-locked arbiter that merges four filter
// streams destined for one egress port into a single registered AXI-Stream output.
module egress_arbiter #(
    parameter int unsigned OUT_PORT   = 0,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] in_tdata  [4],
    input  logic [3:0]            in_tvalid,
    input  logic [3:0]            in_tlast,
    input  logic [1:0]            in_tdest  [4],
    output logic [3:0]            in_tready,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic                  out_tvalid,
    output logic                  out_tlast,
    output logic [1:0]            out_tsrc,
    input  logic                  out_tready,
    output logic [31:0]           frames_out
);

    localparam logic [1:0] OUT_SEL = OUT_PORT[1:0];

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state_reg, state_next;
    logic [1:0]            grant_reg, grant_next;
    logic [1:0]            g_last_reg, g_last_next;
    logic [DATA_WIDTH-1:0] out_tdata_reg;
    logic                  out_tvalid_reg;
    logic                  out_tlast_reg;
    logic [1:0]            out_tsrc_reg;
    logic [31:0]           frames_reg;

    logic [3:0]            req;
    logic [1:0]            pick;
    logic                  found;
    logic                  slice_free;
    logic                  accept;

    // The output slice can take a beat when it is empty or draining this cycle.
    assign slice_free = !out_tvalid_reg || out_tready;

    // tdest only matters at arbitration; once locked, beats follow tvalid alone.
    assign accept = (state_reg == LOCKED) && in_tvalid[grant_reg] && slice_free;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_port
            assign req[gi]       = in_tvalid[gi] && (in_tdest[gi] == OUT_SEL);
            assign in_tready[gi] = (state_reg == LOCKED) && (grant_reg == 2'(gi)) && slice_free;
        end
    endgenerate

    // Round-robin pick: first requester after the last granted input, wrapping mod 4.
    always_comb begin
        logic [1:0] cand;
        pick  = g_last_reg + 2'd1;
        found = 1'b0;
        cand  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = g_last_reg + 2'(k);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // Next-state logic: grant from IDLE, release after the accepted tlast beat.
    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        g_last_next = g_last_reg;
        case (state_reg)
            IDLE: begin
                if (en && found) begin
                    state_next = LOCKED;
                    grant_next = pick;
                end
            end
            LOCKED: begin
                if (accept && in_tlast[grant_reg]) begin
                    state_next  = IDLE;
                    g_last_next = grant_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Arbitration state; g_last resets to 3 so input 0 has first priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            grant_reg  <= 2'd0;
            g_last_reg <= 2'd3;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            g_last_reg <= g_last_next;
        end
    end

    // Registered output slice: load on accept, otherwise drain on out_tready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_tdata_reg  <= '0;
            out_tvalid_reg <= 1'b0;
            out_tlast_reg  <= 1'b0;
            out_tsrc_reg   <= 2'd0;
        end else if (accept) begin
            out_tdata_reg  <= in_tdata[grant_reg];
            out_tvalid_reg <= 1'b1;
            out_tlast_reg  <= in_tlast[grant_reg];
            out_tsrc_reg   <= grant_reg;
        end else if (out_tready) begin
            out_tvalid_reg <= 1'b0;
        end
    end

    // Count frames as their last beat leaves the slice; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frames_reg <= 32'd0;
        end else if (out_tvalid_reg && out_tready && out_tlast_reg) begin
            frames_reg <= frames_reg + 32'd1;
        end
    end

    assign out_tdata  = out_tdata_reg;
    assign out_tvalid = out_tvalid_reg;
    assign out_tlast  = out_tlast_reg;
    assign out_tsrc   = out_tsrc_reg;
    assign frames_out = frames_reg;

endmodule

// File: tb/tb_egress_arbiter.sv
// tb_egress_arbiter: random multi-input traffic against a frame-level
// round-robin model; expected beats are queued and checked by a monitor.
module tb_egress_arbiter;

    localparam int DW   = 16;
    localparam int OP   = 1;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          out_tready = 1'b0;
    logic [DW-1:0] in_tdata [4];
    logic [3:0]    in_tvalid;
    logic [3:0]    in_tlast;
    logic [1:0]    in_tdest [4];
    logic [3:0]    in_tready;
    logic [DW-1:0] out_tdata;
    logic          out_tvalid;
    logic          out_tlast;
    logic [1:0]    out_tsrc;
    logic [31:0]   frames_out;

    egress_arbiter #(.OUT_PORT(OP), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .en(en),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
        .in_tdest(in_tdest), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
        .out_tsrc(out_tsrc), .out_tready(out_tready), .frames_out(frames_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [1:0]    src;
    } beat_t;
    beat_t exp_q[$];

    // Per-input stimulus: one current frame per input.
    int            cur_len  [4];
    logic [1:0]    cur_dest [4];
    logic [DW-1:0] cur_data [4][MAXB];
    int            beat_idx [4];
    bit            active   [4];
    int            gap      [4];
    int            hold     [4];
    int            tready_pct = 100;
    int            en_pct     = 100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic new_frame(input int i);
        cur_len[i]  = $urandom_range(1, MAXB);
        cur_dest[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'(OP);
        for (int b = 0; b < MAXB; b++) cur_data[i][b] = DW'($urandom);
        beat_idx[i] = 0;
        active[i]   = 1'b1;
        hold[i]     = $urandom_range(3, 10);
    endtask

    task automatic drive(input int i);
        if (active[i]) begin
            in_tvalid[i] = (beat_idx[i] == 0) ? 1'b1 : ($urandom_range(0, 99) < 80);
            in_tdata[i]  = cur_data[i][beat_idx[i]];
            in_tlast[i]  = (beat_idx[i] == cur_len[i] - 1);
            // Later beats carry junk tdest: acceptance must ignore it.
            in_tdest[i]  = (beat_idx[i] == 0) ? cur_dest[i] : 2'($urandom_range(0, 3));
        end else begin
            in_tvalid[i] = 1'b0;
            in_tdata[i]  = DW'($urandom);
            in_tlast[i]  = 1'b0;
            in_tdest[i]  = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic step(input int i, input bit acc);
        if (acc) begin
            beat_idx[i]++;
            if (beat_idx[i] == cur_len[i]) begin
                active[i] = 1'b0;
                gap[i]    = $urandom_range(0, 3);
            end
        end else if (active[i] && cur_dest[i] != 2'(OP)) begin
            // A frame for another egress is eventually taken elsewhere.
            if (hold[i] == 0) begin
                active[i] = 1'b0;
                gap[i]    = $urandom_range(0, 3);
            end else begin
                hold[i]--;
            end
        end
        if (!active[i]) begin
            if (gap[i] > 0) gap[i]--;
            else new_frame(i);
        end
        drive(i);
    endtask

    // Reference model: frame-level round robin; pushes a whole frame on each grant.
    bit         m_locked = 1'b0;
    int         m_g      = 0;
    int         m_glast  = 3;
    always @(negedge clk) begin
        if (reset) begin
            m_locked = 1'b0;
            m_glast  = 3;
            exp_q.delete();
        end else begin
            for (int i = 0; i < 4; i++)
                if (!(m_locked && m_g == i)) check("tready_ungranted", 64'(in_tready[i]), 64'd0);
            if (m_locked) check("tready_granted", 64'(in_tready[m_g]), 64'(!out_tvalid || out_tready));
            if (!m_locked) begin
                if (en) begin
                    for (int k = 1; k <= 4; k++) begin
                        int c;
                        c = (m_glast + k) % 4;
                        if (in_tvalid[c] && in_tdest[c] == 2'(OP)) begin
                            m_locked = 1'b1;
                            m_g      = c;
                            for (int b = 0; b < cur_len[c]; b++)
                                exp_q.push_back('{cur_data[c][b], (b == cur_len[c] - 1), 2'(c)});
                            break;
                        end
                    end
                end
            end else if (in_tvalid[m_g] && in_tready[m_g] && in_tlast[m_g]) begin
                m_locked = 1'b0;
                m_glast  = m_g;
            end
        end
    end

    // Monitor: pops expected beats on output handshakes, checks stall stability and count.
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [1:0]    prev_src;
    int            frames_exp = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            frames_exp = 0;
        end else begin
            check("frames_out", 64'(frames_out), 64'(frames_exp));
            if (prev_stall) begin
                check("stall_valid", 64'(out_tvalid), 64'd1);
                check("stall_data", 64'(out_tdata), 64'(prev_data));
                check("stall_last", 64'(out_tlast), 64'(prev_last));
                check("stall_src", 64'(out_tsrc), 64'(prev_src));
            end
            if (out_tvalid && out_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %0h src %0d expected no beat at %0t",
                             out_tdata, out_tsrc, $time);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("out_tdata", 64'(out_tdata), 64'(e.data));
                    check("out_tlast", 64'(out_tlast), 64'(e.last));
                    check("out_tsrc", 64'(out_tsrc), 64'(e.src));
                    if (e.last) frames_exp++;
                end
            end
            prev_stall = out_tvalid && !out_tready;
            prev_data  = out_tdata;
            prev_last  = out_tlast;
            prev_src   = out_tsrc;
        end
    end

    // Stimulus: reset checks, phased random traffic, mid-frame reset, final en=0 drain.
    initial begin
        bit [3:0] acc;
        for (int i = 0; i < 4; i++) begin
            active[i] = 1'b0;
            gap[i]    = 0;
            cur_len[i] = 1;
            beat_idx[i] = 0;
            drive(i);
        end
        #2;
        check("rst_tvalid", 64'(out_tvalid), 64'd0);
        check("rst_tlast", 64'(out_tlast), 64'd0);
        check("rst_tdata", 64'(out_tdata), 64'd0);
        check("rst_tsrc", 64'(out_tsrc), 64'd0);
        check("rst_frames", 64'(frames_out), 64'd0);
        check("rst_tready", 64'(in_tready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        en = 1'b1;
        out_tready = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc < 800)       begin tready_pct = 100; en_pct = 100; end
            else if (cyc < 1600) begin tready_pct = 50;  en_pct = 100; end
            else if (cyc < 2900) begin tready_pct = 85;  en_pct = 80;  end
            else                 begin tready_pct = 100; en_pct = 0;   end
            @(negedge clk);
            acc = in_tvalid & in_tready;
            @(posedge clk);
            #1;
            if (reset) begin
                reset = 1'b0;
                // Frames cut by reset are sent again from their first beat.
                for (int i = 0; i < 4; i++) beat_idx[i] = 0;
                acc = 4'd0;
            end
            en = ($urandom_range(0, 99) < en_pct);
            out_tready = ($urandom_range(0, 99) < tready_pct);
            for (int i = 0; i < 4; i++) step(i, acc[i]);
            if (cyc == 1200) begin
                #2;
                reset = 1'b1;
                #1;
                check("async_rst_tvalid", 64'(out_tvalid), 64'd0);
                check("async_rst_frames", 64'(frames_out), 64'd0);
                check("async_rst_tready", 64'(in_tready), 64'd0);
            end
        end
        @(negedge clk);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("drain_tvalid", 64'(out_tvalid), 64'd0);
        check("drain_model_idle", 64'(m_locked), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
